bus_terminal_fifo: RTL

Per-terminal endpoint on the device side of the `bs_gnrtr_n_rbtr` bus driver, one instance per driver port. It owns the two FIFOs the bus driver talks to:
- TX FIFO: the device writes packets, the bus pops them via `pndng`/`pop`/`D_pop`.
- RX FIFO: the bus writes packets via `push`/`D_push`, the device reads them.

It replaces the behavioural FIFO models the bench drives today with synthesizable RTL.

---
 rtl/bus_terminal_fifo.sv | 125 ++++++++++++
 1 files changed

// File: rtl/bus_terminal_fifo.sv
// bus_terminal_fifo
//   Device-side endpoint for one port of the bs_gnrtr_n_rbtr bus driver.
//   Holds a TX FIFO (device writes, bus pops) and an RX FIFO (bus pushes,
//   device reads). Both FIFOs are first-word-fall-through circular buffers
//   with registered occupancy counters; status outputs come only from
//   registered state.
//
//   Optional feature: define BUS_TERM_ADDR_FILTER_EN to accept only bus
//   pushes whose top id_bits match term_id or bdcst. When it is undefined,
//   every push passes the address check and rx_filt stays 0.
//
// Ports
//   clk, reset (sync, active-low)
//   pndng, D_pop, pop          : bus side of the TX FIFO
//   push, D_push               : bus side of the RX FIFO
//   tx_wr, tx_data, tx_full    : device side of the TX FIFO
//   rx_rd, rx_data, rx_empty   : device side of the RX FIFO
//   tx_count, rx_count         : occupancy
//   tx_ovf, rx_ovf, rx_filt    : one-cycle drop pulses, registered
module bus_terminal_fifo #(
  parameter int                 pckg_sz = 16,
  parameter int                 depth   = 8,
  parameter int                 id_bits = 8,
  parameter logic [id_bits-1:0] term_id = '0,
  parameter logic [id_bits-1:0] bdcst   = '1
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic                         pndng,
  output logic [pckg_sz-1:0]           D_pop,
  input  logic                         pop,
  input  logic                         push,
  input  logic [pckg_sz-1:0]           D_push,
  input  logic                         tx_wr,
  input  logic [pckg_sz-1:0]           tx_data,
  output logic                         tx_full,
  input  logic                         rx_rd,
  output logic [pckg_sz-1:0]           rx_data,
  output logic                         rx_empty,
  output logic [$clog2(depth+1)-1:0]   tx_count,
  output logic [$clog2(depth+1)-1:0]   rx_count,
  output logic                         tx_ovf,
  output logic                         rx_ovf,
  output logic                         rx_filt
);

  localparam int AW = $clog2(depth);
  localparam int CW = $clog2(depth+1);

`ifdef BUS_TERM_ADDR_FILTER_EN
  localparam bit FILT_EN = 1'b1;
`else
  localparam bit FILT_EN = 1'b0;
`endif

  logic [pckg_sz-1:0] tx_mem [depth];
  logic [pckg_sz-1:0] rx_mem [depth];
  logic [AW-1:0]      tx_wp, tx_rp, rx_wp, rx_rp;
  logic [CW-1:0]      tx_cnt, rx_cnt;

  logic tx_do_pop, tx_do_wr, rx_do_rd, rx_do_push;
  logic addr_match, addr_ok;
  logic tx_ovf_p0, rx_ovf_p0, rx_filt_p0;
  logic tx_ovf_p1, rx_ovf_p1, rx_filt_p1;

  // ---- stage p0: accept/drop decisions from registered counts ----
  assign tx_full   = (tx_cnt == CW'(depth));
  assign pndng     = (tx_cnt != '0);
  assign rx_empty  = (rx_cnt == '0);
  assign tx_count  = tx_cnt;
  assign rx_count  = rx_cnt;
  assign D_pop     = tx_mem[tx_rp];
  assign rx_data   = rx_mem[rx_rp];

  // A pop on a full FIFO frees the slot the same-cycle write lands in.
  assign tx_do_pop = pop && pndng;
  assign tx_do_wr  = tx_wr && (!tx_full || tx_do_pop);
  assign tx_ovf_p0 = tx_wr && !tx_do_wr;

  assign addr_match = (D_push[pckg_sz-1 -: id_bits] == term_id) ||
                      (D_push[pckg_sz-1 -: id_bits] == bdcst);
  assign addr_ok    = !FILT_EN || addr_match;

  assign rx_do_rd   = rx_rd && !rx_empty;
  assign rx_do_push = push && addr_ok && ((rx_cnt != CW'(depth)) || rx_do_rd);
  // Filter rejection takes priority, so ovf and filt are mutually exclusive.
  assign rx_filt_p0 = push && !addr_ok;
  assign rx_ovf_p0  = push && addr_ok && !rx_do_push;

  // ---- stage p1: memory writes (data, not reset) ----
  always_ff @(posedge clk) begin
    if (tx_do_wr)   tx_mem[tx_wp] <= tx_data;
    if (rx_do_push) rx_mem[rx_wp] <= D_push;
  end

  // ---- stage p1: pointers, counts and drop pulses (control, reset) ----
  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_wp      <= '0;
      tx_rp      <= '0;
      tx_cnt     <= '0;
      rx_wp      <= '0;
      rx_rp      <= '0;
      rx_cnt     <= '0;
      tx_ovf_p1  <= 1'b0;
      rx_ovf_p1  <= 1'b0;
      rx_filt_p1 <= 1'b0;
    end else begin
      if (tx_do_wr)   tx_wp <= tx_wp + 1'b1;
      if (tx_do_pop)  tx_rp <= tx_rp + 1'b1;
      tx_cnt <= tx_cnt + CW'(tx_do_wr) - CW'(tx_do_pop);
      if (rx_do_push) rx_wp <= rx_wp + 1'b1;
      if (rx_do_rd)   rx_rp <= rx_rp + 1'b1;
      rx_cnt <= rx_cnt + CW'(rx_do_push) - CW'(rx_do_rd);
      tx_ovf_p1  <= tx_ovf_p0;
      rx_ovf_p1  <= rx_ovf_p0;
      rx_filt_p1 <= rx_filt_p0;
    end
  end

  assign tx_ovf  = tx_ovf_p1;
  assign rx_ovf  = rx_ovf_p1;
  assign rx_filt = FILT_EN ? rx_filt_p1 : 1'b0;

endmodule
